// File: rtl/pwm_pkg.sv
// Constants shared by the motor PWM generator and the PWM capture block.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W  = 23;
  localparam int unsigned PWM_PERIOD = 1666667;
  localparam int unsigned SPEED_W    = 2;

  localparam logic [SPEED_W-1:0] DUTY_NONE = 2'b00;
  localparam logic [SPEED_W-1:0] DUTY_LOW  = 2'b01;
  localparam logic [SPEED_W-1:0] DUTY_MID  = 2'b10;
  localparam logic [SPEED_W-1:0] DUTY_HIGH = 2'b11;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_HIGH = 2'd1,
    CAP_LOW  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of one PWM line, decodes a duty code
// and flags lines that stop toggling.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W    = PWM_CNT_W,
  parameter int unsigned TIMEOUT  = 2 * PWM_PERIOD,
  parameter int unsigned MIN_HIGH = 16,
  parameter int unsigned TH_MID   = 1000000,
  parameter int unsigned TH_HIGH  = 1458333
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               pwm_in,
  output logic [CNT_W-1:0]   high_time,
  output logic [CNT_W-1:0]   period,
  output logic [SPEED_W-1:0] duty_code,
  output logic               meas_valid,
  output logic               stuck_high,
  output logic               stuck_low
);

  localparam int unsigned       IDLE_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  MIN_HIGH_C = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0]  TH_MID_C   = CNT_W'(TH_MID);
  localparam logic [CNT_W-1:0]  TH_HIGH_C  = CNT_W'(TH_HIGH);
  localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [SPEED_W-1:0] decode_duty(input logic [CNT_W-1:0] ht);
    logic [SPEED_W-1:0] code;
    if (ht == '0)             code = DUTY_NONE;
    else if (ht < TH_MID_C)   code = DUTY_LOW;
    else if (ht < TH_HIGH_C)  code = DUTY_MID;
    else                      code = DUTY_HIGH;
    return code;
  endfunction

  logic              w_s;
  logic              r_s_d;
  logic              w_rise;
  logic              w_fall;
  logic              w_edge;
  logic              w_expire;
  logic              w_latch;
  logic              w_to_high;
  logic              w_to_low;
  cap_state_e        r_state;
  cap_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_hcnt;
  logic [CNT_W-1:0]  w_hcnt_nxt;
  logic [CNT_W-1:0]  r_pcnt;
  logic [CNT_W-1:0]  w_pcnt_nxt;
  logic [IDLE_W-1:0] r_icnt;
  logic [IDLE_W-1:0] w_icnt_nxt;

  logic [CNT_W-1:0]   r_high_time;
  logic [CNT_W-1:0]   r_period;
  logic [SPEED_W-1:0] r_duty_code;
  logic               r_meas_valid;
  logic               r_stuck_high;
  logic               r_stuck_low;

  sync_2ff u_sync (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_d     (pwm_in),
    .o_q     (w_s)
  );

  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;
  assign w_edge = w_rise | w_fall;

  // The edge cycle counts as the first cycle of the new level, so a level held
  // for exactly TIMEOUT cycles expires and an edge on the expiry cycle wins.
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_pcnt_nxt  = r_pcnt;
    w_icnt_nxt  = r_icnt;
    w_latch     = 1'b0;
    w_to_high   = 1'b0;
    w_to_low    = 1'b0;
    w_expire    = ~w_edge & (r_icnt == IDLE_LAST);

    if (w_edge)                  w_icnt_nxt = IDLE_ONE;
    else if (r_icnt != IDLE_MAX) w_icnt_nxt = r_icnt + IDLE_ONE;

    case (r_state)
      CAP_IDLE: begin
        if (w_rise) begin
          w_state_nxt = CAP_HIGH;
          w_hcnt_nxt  = CNT_ONE;
          w_pcnt_nxt  = CNT_ONE;
        end
      end
      CAP_HIGH: begin
        if (w_fall) begin
          w_state_nxt = (r_hcnt >= MIN_HIGH_C) ? CAP_LOW : CAP_IDLE;
          w_pcnt_nxt  = sat_inc(r_pcnt);
        end else begin
          w_hcnt_nxt = sat_inc(r_hcnt);
          w_pcnt_nxt = sat_inc(r_pcnt);
        end
      end
      CAP_LOW: begin
        if (w_rise) begin
          w_latch     = 1'b1;
          w_state_nxt = CAP_HIGH;
          w_hcnt_nxt  = CNT_ONE;
          w_pcnt_nxt  = CNT_ONE;
        end else begin
          w_pcnt_nxt = sat_inc(r_pcnt);
        end
      end
      default: w_state_nxt = CAP_IDLE;
    endcase

    if (w_expire) begin
      w_state_nxt = CAP_IDLE;
      w_to_high   = w_s;
      w_to_low    = ~w_s;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CAP_IDLE;
      r_hcnt  <= '0;
      r_pcnt  <= '0;
      r_icnt  <= '0;
      r_s_d   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_icnt  <= w_icnt_nxt;
      r_s_d   <= w_s;
    end
  end

  // Published measurement and stuck-line levels.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_high_time  <= '0;
      r_period     <= '0;
      r_duty_code  <= DUTY_NONE;
      r_meas_valid <= 1'b0;
      r_stuck_high <= 1'b0;
      r_stuck_low  <= 1'b0;
    end else begin
      r_meas_valid <= w_latch | w_to_high | w_to_low;
      if (w_latch) begin
        r_high_time <= r_hcnt;
        r_period    <= r_pcnt;
        r_duty_code <= decode_duty(r_hcnt);
      end else if (w_to_high) begin
        r_high_time <= CNT_MAX;
        r_period    <= CNT_MAX;
        r_duty_code <= DUTY_HIGH;
      end else if (w_to_low) begin
        r_high_time <= '0;
        r_period    <= CNT_MAX;
        r_duty_code <= DUTY_NONE;
      end
      if (w_edge) begin
        r_stuck_high <= 1'b0;
        r_stuck_low  <= 1'b0;
      end else begin
        if (w_to_high) r_stuck_high <= 1'b1;
        if (w_to_low)  r_stuck_low  <= 1'b1;
      end
    end
  end

  assign high_time  = r_high_time;
  assign period     = r_period;
  assign duty_code  = r_duty_code;
  assign meas_valid = r_meas_valid;
  assign stuck_high = r_stuck_high;
  assign stuck_low  = r_stuck_low;

endmodule
